led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED step sequencer: two synchronized/debounced buttons drive an IDLE/RUN/PAUSE
// FSM that steps a 4-bit counter up or down once every TICK_DIV cycles while running.
module led_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic       CLK100MHZ,
  input  logic       BTNU,
  input  logic       BTNC,
  input  logic       BTND,
  output logic [3:0] LED,
  output logic       BUSY,
  output logic       DIR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LIMIT  = CW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic       srst;
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign srst    = BTNU;
  assign btn_raw = {BTND, BTNC};

  // Index 0 is the start/pause button, index 1 the direction button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign cnt_next = cnt_reg + CW'(1);

    always_ff @(posedge CLK100MHZ) begin
      if (srst) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        level_reg <= 1'b0;
        press_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= btn_raw[gi];
        sync2_reg <= sync1_reg;
        press_reg <= 1'b0;
        if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_next == DB_LIMIT) begin
          // Accept the new level; only a rising level counts as a press.
          level_reg <= sync2_reg;
          press_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end

    assign press[gi] = press_reg;
  end

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [3:0]    led_reg;
  logic          dir_reg;
  logic          busy_reg;
  logic          c_press;
  logic          d_press;
  logic          tick;

  assign c_press = press[0];
  assign d_press = press[1];
  assign tick    = (state_reg == RUN) && (presc_reg == TICK_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (srst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      led_reg   <= 4'h0;
      dir_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      if (d_press)
        dir_reg <= ~dir_reg;
      case (state_reg)
        IDLE, PAUSE: begin
          if (c_press) begin
            state_reg <= RUN;
            presc_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          // The step uses the pre-toggle direction when a D-press coincides.
          if (tick) begin
            led_reg   <= dir_reg ? led_reg - 4'd1 : led_reg + 4'd1;
            presc_reg <= '0;
          end else begin
            presc_reg <= presc_reg + PW'(1);
          end
          if (c_press) begin
            state_reg <= PAUSE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign LED  = led_reg;
  assign BUSY = busy_reg;
  assign DIR  = dir_reg;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized button stimulus for led_seq_ctrl, checked every cycle against an
// edge-counting behavioural model of the debounce, press and stepping rules.
module tb_led_seq_ctrl;
  localparam int DC = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       btnu, btnc, btnd;
  logic [3:0] led;
  logic       busy, dir;

  always #5 clk = ~clk;

  led_seq_ctrl #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
    .CLK100MHZ(clk),
    .BTNU(btnu),
    .BTNC(btnc),
    .BTND(btnd),
    .LED(led),
    .BUSY(busy),
    .DIR(dir)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: raw-sample delay line, accepted level, disagreement run length,
  // pending press, mode (0 idle, 1 run, 2 pause), edges since RUN entry.
  int m_q1[2], m_q2[2], m_level[2], m_run[2];
  bit m_pend[2];
  int m_mode, m_edges, m_led, m_dir;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_q1[b] = 0; m_q2[b] = 0; m_level[b] = 0; m_run[b] = 0; m_pend[b] = 0;
    end
    m_mode = 0; m_edges = 0; m_led = 0; m_dir = 0;
  endfunction

  function automatic void model_edge(bit u, bit c, bit d);
    bit       cp, dp;
    bit [1:0] raw;
    int       delayed;
    if (u) begin
      model_reset();
      return;
    end
    cp = m_pend[0];
    dp = m_pend[1];
    if (m_mode == 1) begin
      m_edges++;
      if (m_edges % TD == 0)
        m_led = (m_led + (m_dir != 0 ? 15 : 1)) % 16;
    end
    if (cp) begin
      if (m_mode == 1) m_mode = 2;
      else begin
        m_mode  = 1;
        m_edges = 0;
      end
    end
    if (dp) m_dir = 1 - m_dir;
    raw = {d, c};
    for (int b = 0; b < 2; b++) begin
      delayed   = m_q2[b];
      m_q2[b]   = m_q1[b];
      m_q1[b]   = int'(raw[b]);
      m_pend[b] = 0;
      if (delayed == m_level[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_level[b] = delayed;
          m_run[b]   = 0;
          m_pend[b]  = (delayed == 1);
        end
      end
    end
  endfunction

  task automatic cycle(input bit u, input bit c, input bit d);
    btnu = u; btnc = c; btnd = d;
    @(posedge clk);
    model_edge(u, c, d);
    @(negedge clk);
    check("led", 32'(led), 32'(m_led));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("dir", 32'(dir), 32'(m_dir));
  endtask

  initial begin
    int rise;
    btnu = 1'b1; btnc = 1'b0; btnd = 1'b0;
    model_reset();

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dir", 32'(dir), 32'd0);
    $display("reset: led=%0h busy=%0b dir=%0b", led, busy, dir);

    rise = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, i <= 10, 0);
      if (busy && rise < 0) rise = i;
    end
    check("busy_rise_edge", 32'(rise), 32'd7);
    $display("start press: busy rose after edge %0d led=%0h", rise, led);

    cycle(1, 0, 0);
    for (int i = 1; i <= 25; i++) cycle(0, i <= 3, 0);
    check("short_busy", 32'(busy), 32'd0);
    check("short_led", 32'(led), 32'd0);
    $display("short press: busy=%0b led=%0h", busy, led);

    for (int s = 0; s < 150; s++) begin
      int  len, gap;
      bit  c, d;
      if ($urandom_range(0, 39) == 0) begin
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) cycle(1, $urandom_range(0, 1), $urandom_range(0, 1));
        $display("seg %0d: reset %0d cycles", s, len);
      end else begin
        c   = ($urandom_range(0, 2) == 0);
        d   = ($urandom_range(0, 3) == 0);
        len = $urandom_range(1, 10);
        gap = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) cycle(0, c, d);
        for (int i = 0; i < gap; i++) cycle(0, 0, 0);
        $display("seg %0d: c=%0b d=%0b len=%0d gap=%0d -> led=%0h busy=%0b dir=%0b",
                 s, c, d, len, gap, led, busy, dir);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
